// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/load-store memory arbiter: FSM encoding,
// requester IDs and default tuning values.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_e;

    localparam int unsigned DEF_MAX_WAIT = 4;
    localparam int unsigned DEF_TIMEOUT  = 16;
    localparam logic [31:0] ERR_RDATA    = 32'h0;

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority) and a
// flag that is high while the count sits at LIMIT.
module sat_counter #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT_V)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT_V);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between instruction fetch and load/store, with
// fetch anti-starvation, an access watchdog and the core stall output.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_wstrb,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic              m_req,
    output logic              m_we,
    output logic [3:0]        m_wstrb,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    input  logic              m_ack,
    output logic              err,
    output logic              stall
);

    localparam int unsigned STARVE_W = $clog2(MAX_WAIT + 1);
    localparam int unsigned TO_W     = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    src_e              src_q, src_d;
    logic              err_q, err_d;
    logic              m_we_q, m_we_d;
    logic [3:0]        m_wstrb_q, m_wstrb_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [31:0]       m_wdata_q, m_wdata_d;
    logic [31:0]       i_rdata_q, i_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;

    logic starve_inc, starve_clr, starve_lim;
    logic to_inc, to_clr, to_lim;

    sat_counter #(.WIDTH(STARVE_W), .LIMIT(MAX_WAIT)) u_starve_cnt (
        .clk_i      (clk),
        .rst_ni     (rst),
        .inc_i      (starve_inc),
        .clr_i      (starve_clr),
        .at_limit_o (starve_lim)
    );

    // Limit is TIMEOUT-1: the final allowed m_req cycle still accepts m_ack.
    sat_counter #(.WIDTH(TO_W), .LIMIT(TIMEOUT - 1)) u_timeout_cnt (
        .clk_i      (clk),
        .rst_ni     (rst),
        .inc_i      (to_inc),
        .clr_i      (to_clr),
        .at_limit_o (to_lim)
    );

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        err_d      = err_q;
        m_we_d     = m_we_q;
        m_wstrb_d  = m_wstrb_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        starve_inc = 1'b0;
        starve_clr = 1'b0;
        to_inc     = 1'b0;
        to_clr     = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_req && !starve_lim) begin
                    m_we_d     = d_we;
                    m_wstrb_d  = d_wstrb;
                    m_addr_d   = d_addr;
                    m_wdata_d  = d_wdata;
                    src_d      = SRC_D;
                    state_d    = D_ACC;
                    starve_inc = i_req;
                end else if (i_req) begin
                    m_we_d     = 1'b0;
                    m_wstrb_d  = '0;
                    m_addr_d   = i_addr;
                    src_d      = SRC_I;
                    state_d    = I_ACC;
                    starve_clr = 1'b1;
                end
            end
            I_ACC, D_ACC: begin
                if (m_ack || to_lim) begin
                    if (state_q == I_ACC) begin
                        i_rdata_d = m_ack ? m_rdata : ERR_RDATA;
                    end else begin
                        d_rdata_d = m_ack ? m_rdata : ERR_RDATA;
                    end
                    err_d   = !m_ack;
                    state_d = RESP;
                end else begin
                    to_inc = 1'b1;
                end
            end
            RESP: begin
                err_d   = 1'b0;
                to_clr  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            src_q     <= SRC_I;
            err_q     <= 1'b0;
            m_we_q    <= 1'b0;
            m_wstrb_q <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            err_q     <= err_d;
            m_we_q    <= m_we_d;
            m_wstrb_q <= m_wstrb_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign m_req   = (state_q == I_ACC) || (state_q == D_ACC);
    assign m_we    = m_we_q;
    assign m_wstrb = m_wstrb_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_ack   = (state_q == RESP) && (src_q == SRC_I);
    assign d_ack   = (state_q == RESP) && (src_q == SRC_D);
    assign err     = (state_q == RESP) && err_q;
    assign stall   = (i_req && !i_ack) || (d_req && !d_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_rdata;
    logic              i_ack;
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_wstrb;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_ack;
    logic              m_req;
    logic              m_we;
    logic [3:0]        m_wstrb;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;
    logic              m_ack;
    logic              err;
    logic              stall;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(4), .TIMEOUT(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ack   (i_ack),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_wstrb (d_wstrb),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ack   (d_ack),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_wstrb (m_wstrb),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ack   (m_ack),
        .err     (err),
        .stall   (stall)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int unsigned n = 1);
        for (int unsigned k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_wstrb = '0; d_addr = '0; d_wdata = '0; m_rdata = '0; m_ack = 1'b0;
        #1;
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_m_addr", 32'(m_addr), 32'd0);
        chk("rst_rdata", i_rdata | d_rdata, 32'd0);
        tick(2);
        rst = 1'b1;
        tick();

        // single fetch
        i_req = 1'b1; i_addr = 12'h010;
        #1 chk("f_stall_pend", 32'(stall), 32'd1);
        tick();
        chk("f_m_req", 32'(m_req), 32'd1);
        chk("f_m_addr", 32'(m_addr), 32'h010);
        chk("f_m_we", 32'(m_we), 32'd0);
        chk("f_no_ack_yet", 32'(i_ack), 32'd0);
        m_ack = 1'b1; m_rdata = 32'h00500093;
        tick();
        m_ack = 1'b0;
        chk("f_i_ack", 32'(i_ack), 32'd1);
        chk("f_i_rdata", i_rdata, 32'h00500093);
        chk("f_m_req_low", 32'(m_req), 32'd0);
        chk("f_err", 32'(err), 32'd0);
        chk("f_stall_done", 32'(stall), 32'd0);
        i_req = 1'b0;
        tick();
        chk("f_ack_pulse", 32'(i_ack), 32'd0);

        // simultaneous: store wins first
        i_req = 1'b1; i_addr = 12'h010;
        d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'hF; d_addr = 12'h100; d_wdata = 32'hCAFEF00D;
        tick();
        chk("s_m_addr_d", 32'(m_addr), 32'h100);
        chk("s_m_we", 32'(m_we), 32'd1);
        chk("s_m_wstrb", 32'(m_wstrb), 32'hF);
        chk("s_m_wdata", m_wdata, 32'hCAFEF00D);
        m_ack = 1'b1; m_rdata = 32'h0BADC0DE;
        tick();
        m_ack = 1'b0;
        chk("s_d_ack", {30'd0, i_ack, d_ack}, 32'd1);
        chk("s_d_rdata", d_rdata, 32'h0BADC0DE);
        chk("s_err_d", 32'(err), 32'd0);
        chk("s_stall_i", 32'(stall), 32'd1);
        d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'h0;
        tick(2);
        chk("s_m_addr_i", 32'(m_addr), 32'h010);
        chk("s_m_we_i", {27'd0, m_we, m_wstrb}, 32'd0);
        m_ack = 1'b1; m_rdata = 32'h11111111;
        tick();
        m_ack = 1'b0;
        chk("s_i_ack", {30'd0, i_ack, d_ack}, 32'd2);
        chk("s_i_rdata", i_rdata, 32'h11111111);
        chk("s_err_i", 32'(err), 32'd0);
        i_req = 1'b0;
        tick();

        // starvation: four loads, then fetch forced through
        i_req = 1'b1; i_addr = 12'h010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h200;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk($sformatf("sv_grant%0d", g), 32'(m_addr), (g < 4) ? 32'h200 : 32'h010);
            m_ack = 1'b1; m_rdata = 32'hA5A50000 + 32'(g);
            tick();
            m_ack = 1'b0;
            chk($sformatf("sv_ack%0d", g), {30'd0, i_ack, d_ack}, (g < 4) ? 32'd1 : 32'd2);
            if (g == 4) i_req = 1'b0;
            tick();
        end
        tick();
        chk("sv_d_after", 32'(m_addr), 32'h200);
        m_ack = 1'b1; m_rdata = 32'h5A5A5A5A;
        tick();
        m_ack = 1'b0;
        chk("sv_d_after_ack", 32'(d_ack), 32'd1);
        d_req = 1'b0;
        tick();

        // timeout: no m_ack for 16 m_req cycles
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h300; m_rdata = 32'hDEADBEEF;
        tick();
        chk("t_m_req_c1", 32'(m_req), 32'd1);
        tick(15);
        chk("t_m_req_c16", 32'(m_req), 32'd1);
        chk("t_no_ack_c16", 32'(d_ack), 32'd0);
        tick();
        chk("t_d_ack", 32'(d_ack), 32'd1);
        chk("t_err", 32'(err), 32'd1);
        chk("t_d_rdata", d_rdata, 32'h0);
        chk("t_m_req_low", 32'(m_req), 32'd0);
        d_req = 1'b0;
        tick();
        chk("t_err_clear", 32'(err), 32'd0);

        // ack arriving in the last allowed cycle is a success
        d_req = 1'b1; d_addr = 12'h304;
        tick(16);
        chk("e_m_req_c16", 32'(m_req), 32'd1);
        m_ack = 1'b1; m_rdata = 32'h12345678;
        tick();
        m_ack = 1'b0;
        chk("e_d_ack", 32'(d_ack), 32'd1);
        chk("e_err", 32'(err), 32'd0);
        chk("e_d_rdata", d_rdata, 32'h12345678);
        d_req = 1'b0;
        tick();

        // reset mid-access
        i_req = 1'b1; i_addr = 12'h040;
        tick();
        chk("r_m_req_pre", 32'(m_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("r_m_req_async", 32'(m_req), 32'd0);
        chk("r_acks", {29'd0, err, i_ack, d_ack}, 32'd0);
        chk("r_m_addr", 32'(m_addr), 32'd0);
        i_req = 1'b0;
        #1 chk("r_stall", 32'(stall), 32'd0);
        tick(2);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("r_no_spur%0d", c), {29'd0, err, i_ack, d_ack}, 32'd0);
        end
        i_req = 1'b1; i_addr = 12'h050;
        tick();
        chk("r_fresh_addr", 32'(m_addr), 32'h050);
        m_ack = 1'b1; m_rdata = 32'h0000ABCD;
        tick();
        m_ack = 1'b0;
        chk("r_fresh_ack", 32'(i_ack), 32'd1);
        chk("r_fresh_rdata", i_rdata, 32'h0000ABCD);
        i_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
